agc_mpdv_sequencer: RTL

- Sequences the multiply/divide (MP/DV) datapath across multiple memory cycle times (MCTs).
- Generates a timepulse count and a stage count, and emits one-cycle datapath strobes at fixed timepulses.
- Latches the sign/overflow branch bits BR1/BR2 and returns the per-stage quotient bit.
- Sits between instruction decode (start/op) and the stage-branch logic feeding the write/read bus controls.

---
 rtl/agc_mpdv_sequencer.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/agc_mpdv_sequencer.sv
// Multiply/divide sequencer: steps timepulse and stage counters across several MCTs,
// emits datapath strobes at fixed timepulses and keeps the BR1/BR2 sign/overflow branch bits.
module agc_mpdv_sequencer #(
   parameter int NUM_TP = 12,
   parameter int MP_MCT = 3,
   parameter int DV_MCT = 6
) (
   input  logic       CLOCK,
   input  logic       rst_,
   input  logic       START,
   input  logic       OPDV,
   input  logic       GOJAM,
   input  logic       MPBIT,
   input  logic       SUMA16_,
   input  logic       OVF_,
   output logic       BUSY,
   output logic [3:0] TP,
   output logic [2:0] STG,
   output logic       LDY,
   output logic       SHFT,
   output logic       ADDSUB,
   output logic       SUB,
   output logic       QBIT,
   output logic       QVAL,
   output logic       BR1,
   output logic       BR2,
   output logic       DONE
);

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   localparam logic [3:0] TP_LAST  = 4'(NUM_TP);
   localparam logic [3:0] TP_LDY   = 4'd2;
   localparam logic [3:0] TP_SHFT  = 4'd6;
   localparam logic [3:0] TP_ADD   = 4'd7;
   localparam logic [3:0] TP_BR    = 4'd8;
   localparam logic [3:0] TP_QBIT  = 4'd9;
   localparam logic [2:0] STG_MP_LAST = 3'(MP_MCT - 1);
   localparam logic [2:0] STG_DV_LAST = 3'(DV_MCT - 1);

   state_t     state;
   state_t     next_state;
   logic [3:0] tp_q;
   logic [3:0] tp_d;
   logic [2:0] stg_q;
   logic [2:0] stg_d;
   logic       op_q;
   logic       br1_q;
   logic       br2_q;
   logic       accept;
   logic       abort;
   logic       run;
   logic       bad_decode;
   logic       last_cycle;
   logic [2:0] last_stg;

   assign run        = (state == RUN);
   assign last_stg   = op_q ? STG_DV_LAST : STG_MP_LAST;
   // Counter values outside the legal range cannot occur normally; treat them as a forced exit.
   assign bad_decode = run && ((tp_q == 4'd0) || (tp_q > TP_LAST) || (stg_q > last_stg));
   assign last_cycle = run && (tp_q == TP_LAST) && (stg_q == last_stg);

   always_comb begin
      next_state = state;
      tp_d       = tp_q;
      stg_d      = stg_q;
      accept     = 1'b0;
      abort      = 1'b0;
      case (state)
         IDLE: begin
            tp_d  = 4'd0;
            stg_d = 3'd0;
            if (START && !GOJAM) begin
               next_state = RUN;
               tp_d       = 4'd1;
               accept     = 1'b1;
            end
         end
         RUN: begin
            if (GOJAM || bad_decode || last_cycle) begin
               next_state = IDLE;
               tp_d       = 4'd0;
               stg_d      = 3'd0;
               abort      = GOJAM;
            end else if (tp_q == TP_LAST) begin
               tp_d  = 4'd1;
               stg_d = stg_q + 3'd1;
            end else begin
               tp_d = tp_q + 4'd1;
            end
         end
         default: begin
            next_state = IDLE;
            tp_d       = 4'd0;
            stg_d      = 3'd0;
         end
      endcase
   end

   always_ff @(posedge CLOCK or negedge rst_) begin
      if (!rst_) begin
         state <= IDLE;
         tp_q  <= 4'd0;
         stg_q <= 3'd0;
         op_q  <= 1'b0;
      end else begin
         state <= next_state;
         tp_q  <= tp_d;
         stg_q <= stg_d;
         if (accept) begin
            op_q <= OPDV;
         end
      end
   end

   // Branch bits survive into IDLE so the datapath can still read the final result.
   always_ff @(posedge CLOCK or negedge rst_) begin
      if (!rst_) begin
         br1_q <= 1'b0;
         br2_q <= 1'b0;
      end else if (accept || abort) begin
         br1_q <= 1'b0;
         br2_q <= 1'b0;
      end else if (run && (tp_q == TP_BR)) begin
         br1_q <= ~SUMA16_;
         br2_q <= ~OVF_;
      end
   end

   assign BUSY   = run;
   assign TP     = tp_q;
   assign STG    = stg_q;
   assign LDY    = run && (tp_q == TP_LDY) && (stg_q == 3'd0);
   assign SHFT   = run && (tp_q == TP_SHFT);
   assign ADDSUB = run && (tp_q == TP_ADD) && (op_q || MPBIT);
   assign SUB    = run && op_q;
   assign QBIT   = run && (tp_q == TP_QBIT) && op_q;
   assign QVAL   = run && !br1_q;
   assign BR1    = br1_q;
   assign BR2    = br2_q;
   assign DONE   = last_cycle && !GOJAM;

endmodule
